// File: rtl/alu_share_arbiter.sv
// Round-robin front end sharing one multi-cycle ALU among NREQ requesters,
// with a watchdog that aborts operations the ALU never completes.
module alu_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 63,
  parameter int IW      = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [2*NREQ-1:0]    req_mode,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [63:0]          resp_data,
  output logic                 resp_err,
  output logic [IW-1:0]        grant_id,
  output logic                 busy,
  output logic                 alu_valid,
  output logic [1:0]           alu_mode,
  output logic [31:0]          alu_in_a,
  output logic [31:0]          alu_in_b,
  input  logic                 alu_ready,
  input  logic [63:0]          alu_out
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [1:0]    mode_q, mode_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [63:0]   data_q, data_d;
  logic          err_q, err_d;

  logic          found;
  logic [IW-1:0] win;
  logic [1:0]    win_mode;
  logic [31:0]   win_a;
  logic [31:0]   win_b;
  logic          resp_ack;

  // Wrap-around scan from ptr_q; the inner loop keeps every index constant.
  always_comb begin
    int unsigned sel;
    found    = 1'b0;
    win      = '0;
    win_mode = '0;
    win_a    = '0;
    win_b    = '0;
    sel      = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      sel = int'(ptr_q) + off;
      if (sel >= NREQ) sel = sel - NREQ;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && sel == i && req_valid[i]) begin
          found = 1'b1;
          win   = IW'(i);
        end
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) begin
        win_mode = req_mode[2*i +: 2];
        win_a    = req_a[32*i +: 32];
        win_b    = req_b[32*i +: 32];
      end
    end
  end

  always_comb begin
    resp_ack = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q == IW'(i) && resp_ready[i]) resp_ack = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      mode_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      timer_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // A real alu_ready beats the watchdog when both land in the same cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    timer_d = timer_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = win;
          mode_d  = win_mode;
          a_d     = win_a;
          b_d     = win_b;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (alu_ready) begin
          data_d  = alu_out;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        if (resp_ack) begin
          ptr_d   = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i]  = (state_q == IDLE) && found && (win == IW'(i));
      resp_valid[i] = (state_q == RESP) && (grant_q == IW'(i));
    end
    alu_valid = (state_q == ISSUE);
    busy      = (state_q != IDLE);
    alu_mode  = mode_q;
    alu_in_a  = a_q;
    alu_in_b  = b_q;
    grant_id  = grant_q;
    resp_data = data_q;
    resp_err  = err_q;
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter with a behavioural ALU and an expected-result queue.
module tb_alu_share_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 63;
  localparam int IW      = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [2*NREQ-1:0] req_mode = '0;
  logic [32*NREQ-1:0] req_a = '0;
  logic [32*NREQ-1:0] req_b = '0;
  logic [NREQ-1:0]   resp_valid;
  logic [NREQ-1:0]   resp_ready = '0;
  logic [63:0]       resp_data;
  logic              resp_err;
  logic [IW-1:0]     grant_id;
  logic              busy;
  logic              alu_valid;
  logic [1:0]        alu_mode;
  logic [31:0]       alu_in_a;
  logic [31:0]       alu_in_b;
  logic              alu_ready;
  logic [63:0]       alu_out;

  logic              m_ready = 1'b0;
  logic [63:0]       m_out = '0;
  logic [63:0]       m_res = '0;
  int                m_cnt = 0;
  logic              alu_hang = 1'b0;
  logic              inj_ready = 1'b0;
  logic [63:0]       inj_out = '0;

  int cyc = 0;
  int checks = 0;
  int passed = 0;

  typedef struct {
    int          id;
    logic [63:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  assign alu_ready = m_ready | inj_ready;
  assign alu_out   = inj_ready ? inj_out : m_out;

  alu_share_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .grant_id(grant_id), .busy(busy),
    .alu_valid(alu_valid), .alu_mode(alu_mode),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_ready(alu_ready), .alu_out(alu_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] alu_func(logic [1:0] m, logic [31:0] a, logic [31:0] b);
    case (m)
      2'd0:    return {32'd0, a} * {32'd0, b};
      2'd1:    return (b == 0) ? '1 : {a % b, a / b};
      2'd2:    return {32'd0, a} << b[4:0];
      default: return ({32'd0, a} + {32'd0, b}) >> 1;
    endcase
  endfunction

  // ALU model: mulu/divu ready 33 cycles after the start pulse, shift/avg after 2.
  always @(negedge clk) begin
    m_ready = 1'b0;
    if (!rst_n) begin
      m_cnt = 0;
    end else begin
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_ready = 1'b1;
          m_out   = m_res;
        end
      end
      if (alu_valid && !alu_hang) begin
        m_cnt = (alu_mode < 2'd2) ? 33 : 2;
        m_res = alu_func(alu_mode, alu_in_a, alu_in_b);
      end
    end
  end

  task automatic set_req(input int i, input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    req_mode  = (req_mode & ~(8'h3 << (2*i))) | (8'(m) << (2*i));
    req_a     = (req_a & ~({96'd0, 32'hFFFF_FFFF} << (32*i))) | ({96'd0, a} << (32*i));
    req_b     = (req_b & ~({96'd0, 32'hFFFF_FFFF} << (32*i))) | ({96'd0, b} << (32*i));
    req_valid = req_valid | (4'b0001 << i);
  endtask

  task automatic push_exp(input int id, input logic [63:0] data, input logic err);
    exp_t e;
    e.id = id; e.data = data; e.err = err;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; resp_ready = '0; inj_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if ({req_ready, resp_valid, resp_err, busy, alu_valid} !== '0) $display("FAIL reset_ctrl: got %0h want 0", {req_ready, resp_valid, resp_err, busy, alu_valid}); else passed++;
    checks++; if (resp_data !== 64'd0) $display("FAIL reset_data: got %0h want 0", resp_data); else passed++;
    checks++; if ({grant_id, alu_mode, alu_in_a, alu_in_b} !== '0) $display("FAIL reset_alu_if: got %0h want 0", {grant_id, alu_mode, alu_in_a, alu_in_b}); else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if ({req_ready, busy} !== '0) $display("FAIL reset_idle_noreq: got %0h want 0", {req_ready, busy}); else passed++;
  endtask

  task automatic test_single_mulu();
    int t0, n; exp_t e;
    @(negedge clk); set_req(2, 2'd0, 32'd3, 32'd5); push_exp(2, 64'd15, 1'b0); #1;
    t0 = cyc;
    checks++; if (req_ready !== 4'b0100) $display("FAIL mulu_req_ready: got %b want 0100", req_ready); else passed++;
    @(negedge clk); req_valid = '0; #1;
    checks++; if (alu_valid !== 1'b1 || cyc != t0 + 1) $display("FAIL mulu_issue: got valid=%b cyc=%0d want 1 at %0d", alu_valid, cyc, t0 + 1); else passed++;
    checks++; if ({alu_mode, alu_in_a, alu_in_b} !== {2'd0, 32'd3, 32'd5}) $display("FAIL mulu_operands: got %0h want %0h", {alu_mode, alu_in_a, alu_in_b}, {2'd0, 32'd3, 32'd5}); else passed++;
    checks++; if (busy !== 1'b1 || grant_id !== 3'd2) $display("FAIL mulu_owner: got busy=%b id=%0d want 1/2", busy, grant_id); else passed++;
    @(negedge clk); #1;
    checks++; if (alu_valid !== 1'b0) $display("FAIL mulu_pulse_len: got %b want 0", alu_valid); else passed++;
    n = 0;
    while (resp_valid == '0 && n < 200) begin @(negedge clk); #1; n++; end
    checks++; if (cyc != t0 + 35) $display("FAIL mulu_latency: got cycle %0d want %0d", cyc - t0, 35); else passed++;
    e = sb.pop_front();
    checks++; if (resp_valid !== (4'b0001 << e.id)) $display("FAIL mulu_resp_valid: got %b want %b", resp_valid, 4'b0001 << e.id); else passed++;
    checks++; if (resp_data !== e.data || resp_err !== e.err) $display("FAIL mulu_resp_data: got %0h/%b want %0h/%b", resp_data, resp_err, e.data, e.err); else passed++;
    repeat (3) @(negedge clk); #1;
    checks++; if (resp_valid !== (4'b0001 << e.id) || resp_data !== e.data) $display("FAIL mulu_resp_hold: got %b/%0h want %b/%0h", resp_valid, resp_data, 4'b0001 << e.id, e.data); else passed++;
    @(negedge clk); resp_ready = 4'b0100;
    @(negedge clk); resp_ready = '0; #1;
    checks++; if (resp_valid !== '0 || busy !== 1'b0) $display("FAIL mulu_release: got %b/%b want 0/0", resp_valid, busy); else passed++;
  endtask

  task automatic test_round_robin();
    int n; bit nog; exp_t e;
    do_reset();
    @(negedge clk);
    resp_ready = '1;
    for (int i = 0; i < 4; i++) set_req(i, 2'd3, 32'(6 + 2*i), 32'(10 + 2*i));
    for (int k = 0; k < 5; k++) push_exp(k % 4, 64'(8 + 2*(k % 4)), 1'b0);
    #1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (req_ready == '0 && n < 100) begin @(negedge clk); #1; n++; end
      e = sb[0];
      checks++; if (req_ready !== (4'b0001 << e.id)) $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, 4'b0001 << e.id); else passed++;
      @(negedge clk); if (k == 4) req_valid = '0; #1;
      checks++; if (busy !== 1'b1 || int'(grant_id) != e.id) $display("FAIL rr_owner%0d: got %b/%0d want 1/%0d", k, busy, grant_id, e.id); else passed++;
      nog = 1'b1; n = 0;
      while (resp_valid == '0 && n < 100) begin
        if (req_ready != '0) nog = 1'b0;
        @(negedge clk); #1; n++;
      end
      checks++; if (!nog) $display("FAIL rr_no_grant_busy%0d: got grant while busy want none", k); else passed++;
      e = sb.pop_front();
      checks++; if (resp_valid !== (4'b0001 << e.id) || resp_data !== e.data || resp_err !== e.err) $display("FAIL rr_resp%0d: got %b/%0h/%b want %b/%0h/%b", k, resp_valid, resp_data, resp_err, 4'b0001 << e.id, e.data, e.err); else passed++;
      @(negedge clk); #1;
    end
    resp_ready = '0;
  endtask

  task automatic test_backpressure();
    int t0, n; bit stable; exp_t e;
    @(negedge clk);
    resp_ready = 4'b1000;
    set_req(1, 2'd3, 32'd20, 32'd30); set_req(3, 2'd2, 32'd1, 32'd4);
    push_exp(1, 64'd25, 1'b0); push_exp(3, 64'd16, 1'b0); #1;
    t0 = cyc;
    checks++; if (req_ready !== 4'b0010) $display("FAIL bp_grant_first: got %b want 0010", req_ready); else passed++;
    @(negedge clk); req_valid = req_valid & ~4'b0010; #1;
    n = 0;
    while (resp_valid == '0 && n < 100) begin @(negedge clk); #1; n++; end
    checks++; if (cyc != t0 + 4) $display("FAIL avg_latency: got %0d want 4", cyc - t0); else passed++;
    e = sb.pop_front();
    checks++; if (resp_valid !== (4'b0001 << e.id) || resp_data !== e.data || resp_err !== e.err) $display("FAIL bp_resp: got %b/%0h/%b want %b/%0h/%b", resp_valid, resp_data, resp_err, 4'b0001 << e.id, e.data, e.err); else passed++;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk); #1;
      if (resp_valid !== (4'b0001 << e.id) || resp_data !== e.data || resp_err !== 1'b0 || req_ready !== '0) stable = 1'b0;
    end
    checks++; if (!stable) $display("FAIL bp_hold: got change during backpressure (valid=%b data=%0h ready=%b) want stable", resp_valid, resp_data, req_ready); else passed++;
    @(negedge clk); resp_ready = 4'b0010;
    @(negedge clk); resp_ready = 4'b1000; #1;
    checks++; if (resp_valid !== '0 || busy !== 1'b0) $display("FAIL bp_release_idle: got %b/%b want 0/0", resp_valid, busy); else passed++;
    checks++; if (req_ready !== 4'b1000) $display("FAIL bp_next_grant: got %b want 1000", req_ready); else passed++;
    t0 = cyc;
    @(negedge clk); req_valid = '0; #1;
    n = 0;
    while (resp_valid == '0 && n < 100) begin @(negedge clk); #1; n++; end
    checks++; if (cyc != t0 + 4) $display("FAIL shift_latency: got %0d want 4", cyc - t0); else passed++;
    e = sb.pop_front();
    checks++; if (resp_valid !== (4'b0001 << e.id) || resp_data !== e.data || resp_err !== e.err) $display("FAIL shift_resp: got %b/%0h/%b want %b/%0h/%b", resp_valid, resp_data, resp_err, 4'b0001 << e.id, e.data, e.err); else passed++;
    @(negedge clk); resp_ready = '0; #1;
    checks++; if (busy !== 1'b0) $display("FAIL shift_release: got busy=%b want 0", busy); else passed++;
  endtask

  task automatic test_watchdog();
    int t0, n; exp_t e;
    alu_hang = 1'b1;
    @(negedge clk); set_req(0, 2'd0, 32'd7, 32'd9); push_exp(0, 64'd0, 1'b1); #1;
    t0 = cyc;
    checks++; if (req_ready !== 4'b0001) $display("FAIL wd_grant: got %b want 0001", req_ready); else passed++;
    @(negedge clk); req_valid = '0; #1;
    n = 0;
    while (resp_valid == '0 && n < 200) begin @(negedge clk); #1; n++; end
    checks++; if (cyc != t0 + TIMEOUT + 2) $display("FAIL wd_latency: got %0d want %0d", cyc - t0, TIMEOUT + 2); else passed++;
    e = sb.pop_front();
    checks++; if (resp_valid !== (4'b0001 << e.id) || resp_data !== e.data || resp_err !== e.err) $display("FAIL wd_resp: got %b/%0h/%b want %b/%0h/%b", resp_valid, resp_data, resp_err, 4'b0001 << e.id, e.data, e.err); else passed++;
    @(negedge clk); resp_ready = 4'b0001;
    @(negedge clk); resp_ready = '0; #1;
    checks++; if (busy !== 1'b0) $display("FAIL wd_release: got busy=%b want 0", busy); else passed++;

    @(negedge clk); set_req(1, 2'd0, 32'd2, 32'd3); push_exp(1, 64'hDEAD_BEEF_0123_4567, 1'b0); #1;
    t0 = cyc;
    checks++; if (req_ready !== 4'b0010) $display("FAIL wd_edge_grant: got %b want 0010", req_ready); else passed++;
    @(negedge clk); req_valid = '0;
    while (cyc < t0 + TIMEOUT + 1) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b1 || resp_valid !== '0) $display("FAIL wd_edge_not_yet: got %b/%b want 1/0", busy, resp_valid); else passed++;
    inj_out = 64'hDEAD_BEEF_0123_4567; inj_ready = 1'b1;
    @(negedge clk); inj_ready = 1'b0; #1;
    e = sb.pop_front();
    checks++; if (resp_valid !== (4'b0001 << e.id) || resp_data !== e.data || resp_err !== e.err) $display("FAIL wd_edge_resp: got %b/%0h/%b want %b/%0h/%b", resp_valid, resp_data, resp_err, 4'b0001 << e.id, e.data, e.err); else passed++;
    @(negedge clk); resp_ready = 4'b0010;
    @(negedge clk); resp_ready = '0;
    alu_hang = 1'b0;
  endtask

  task automatic test_spurious();
    int n; exp_t e;
    @(negedge clk); inj_out = 64'h1111_2222_3333_4444; inj_ready = 1'b1;
    @(negedge clk); inj_ready = 1'b0; #1;
    checks++; if (busy !== 1'b0 || resp_valid !== '0) $display("FAIL spur_idle_state: got %b/%b want 0/0", busy, resp_valid); else passed++;
    checks++; if (resp_data !== 64'hDEAD_BEEF_0123_4567) $display("FAIL spur_idle_data: got %0h want deadbeef01234567", resp_data); else passed++;
    @(negedge clk); set_req(2, 2'd3, 32'd40, 32'd2); push_exp(2, 64'd21, 1'b0); #1;
    checks++; if (req_ready !== 4'b0100) $display("FAIL spur_grant: got %b want 0100", req_ready); else passed++;
    @(negedge clk); req_valid = '0; #1;
    n = 0;
    while (resp_valid == '0 && n < 100) begin @(negedge clk); #1; n++; end
    e = sb.pop_front();
    checks++; if (resp_valid !== (4'b0001 << e.id) || resp_data !== e.data) $display("FAIL spur_op_resp: got %b/%0h want %b/%0h", resp_valid, resp_data, 4'b0001 << e.id, e.data); else passed++;
    @(negedge clk); inj_out = 64'hABCD_0000_ABCD_0000; inj_ready = 1'b1;
    @(negedge clk); inj_ready = 1'b0; #1;
    checks++; if (resp_valid !== (4'b0001 << e.id) || resp_data !== e.data || resp_err !== e.err) $display("FAIL spur_resp_hold: got %b/%0h/%b want %b/%0h/%b", resp_valid, resp_data, resp_err, 4'b0001 << e.id, e.data, e.err); else passed++;
    @(negedge clk); resp_ready = 4'b0100;
    @(negedge clk); resp_ready = '0; #1;
    checks++; if (busy !== 1'b0) $display("FAIL spur_release: got busy=%b want 0", busy); else passed++;
  endtask

  task automatic test_reset_mid_wait();
    int n; exp_t e;
    @(negedge clk); set_req(1, 2'd0, 32'd11, 32'd13); #1;
    checks++; if (req_ready !== 4'b0010) $display("FAIL rst_pre_grant: got %b want 0010", req_ready); else passed++;
    @(negedge clk); req_valid = '0;
    repeat (10) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b1 || alu_in_a !== 32'd11) $display("FAIL rst_pre_busy: got %b/%0d want 1/11", busy, alu_in_a); else passed++;
    #1; rst_n = 1'b0; #1;
    checks++; if ({req_ready, resp_valid, resp_err, busy, alu_valid} !== '0) $display("FAIL rst_async_ctrl: got %0h want 0", {req_ready, resp_valid, resp_err, busy, alu_valid}); else passed++;
    checks++; if ({grant_id, alu_mode, alu_in_a, alu_in_b, resp_data} !== '0) $display("FAIL rst_async_data: got %0h want 0", {grant_id, alu_mode, alu_in_a, alu_in_b, resp_data}); else passed++;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    resp_ready = '1;
    set_req(0, 2'd3, 32'd1, 32'd3); set_req(3, 2'd3, 32'd5, 32'd7);
    push_exp(0, 64'd2, 1'b0); push_exp(3, 64'd6, 1'b0); #1;
    checks++; if (req_ready !== 4'b0001) $display("FAIL rst_ptr_zero: got %b want 0001", req_ready); else passed++;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (req_ready == '0 && n < 100) begin @(negedge clk); #1; n++; end
      e = sb[0];
      checks++; if (req_ready !== (4'b0001 << e.id)) $display("FAIL rst_grant%0d: got %b want %b", k, req_ready, 4'b0001 << e.id); else passed++;
      @(negedge clk); req_valid = req_valid & ~(4'b0001 << e.id); #1;
      n = 0;
      while (resp_valid == '0 && n < 100) begin @(negedge clk); #1; n++; end
      e = sb.pop_front();
      checks++; if (resp_valid !== (4'b0001 << e.id) || resp_data !== e.data || resp_err !== e.err) $display("FAIL rst_resp%0d: got %b/%0h/%b want %b/%0h/%b", k, resp_valid, resp_data, resp_err, 4'b0001 << e.id, e.data, e.err); else passed++;
      @(negedge clk); #1;
    end
    resp_ready = '0;
  endtask

  initial begin
    test_reset();
    test_single_mulu();
    test_round_robin();
    test_backpressure();
    test_watchdog();
    test_spurious();
    test_reset_mid_wait();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion want finish within limit");
    $fatal(1);
  end

endmodule
